ysyx_22051013_axi_lsu_rd_master: RTL and testbench

Parametrised AXI4 read master for the LSU load path. It accepts one load request at a time from the LSU and issues a single-beat AXI read. It extracts the addressed byte lanes from the returned data beat and sign- or zero-extends them to DATA_W. It then returns one registered response with an error flag. It sits between the LSU and the AXI interconnect/arbiter, and provides the real AR/R handshaking, alignment checking and ID filtering that the earlier always-valid fetch-style master lacks.

---
 rtl/ysyx_22051013_axi_lsu_rd_master_if.sv | 43 ++++
 rtl/ysyx_22051013_axi_lsu_rd_master.sv | 148 ++++++++++++++
 tb/tb_ysyx_22051013_axi_lsu_rd_master.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_axi_lsu_rd_master_if.sv
// LSU load request/response and AXI4 AR/R channel bundle for the LSU read master.
// The master modport is the read master's view; the slave modport is the LSU plus interconnect side.
interface ysyx_22051013_axi_lsu_rd_master_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic              req_signed;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic [ID_W-1:0]   r_id;
  logic              r_last;

  modport master (
    input  req_valid, req_addr, req_size, req_signed,
    input  ar_ready, r_valid, r_data, r_resp, r_id, r_last,
    output req_ready, resp_valid, resp_data, resp_err,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready
  );

  modport slave (
    output req_valid, req_addr, req_size, req_signed,
    output ar_ready, r_valid, r_data, r_resp, r_id, r_last,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready
  );
endinterface

// File: rtl/ysyx_22051013_axi_lsu_rd_master.sv
// Single-beat AXI4 read master for LSU loads: alignment check, AR/R handshake,
// ID filtering, and byte-lane extraction with sign/zero extension.
module ysyx_22051013_axi_lsu_rd_master #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int ARID   = 1
) (
  input logic clk,
  input logic rst,
  ysyx_22051013_axi_lsu_rd_master_if.master bus
);
  localparam int LANE_W = $clog2(DATA_W / 8);
  localparam int BIDX_W = $clog2(DATA_W);
  localparam logic [ID_W-1:0] ARID_V = ID_W'(ARID);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RSP} state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic              signed_q, signed_d;
  logic              req_illegal;
  logic              beat_ok;
  logic [1:0]        unused_bits;

  assign unused_bits = {bus.r_last, bus.r_resp[0]};

  // Shift the addressed lane down, then keep 8<<size bits and fill the rest.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] beat,
                                                    input logic [LANE_W-1:0] lane,
                                                    input logic [2:0]        size,
                                                    input logic              sgn);
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ext;
    logic [BIDX_W-1:0] msb_idx;
    logic              fill;
    raw     = beat >> {lane, 3'b000};
    msb_idx = BIDX_W'((32'd8 << size) - 32'd1);
    fill    = sgn & raw[msb_idx];
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i <= int'(msb_idx)) ? raw[i] : fill;
    end
    return ext;
  endfunction

  assign req_illegal = (bus.req_size > 3'(LANE_W)) ||
                       (|(bus.req_addr[7:0] & 8'((9'd1 << bus.req_size) - 9'd1)));
  assign beat_ok     = bus.r_valid && (bus.r_id == ARID_V);

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    ar_valid_d   = ar_valid_q;
    r_ready_d    = r_ready_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    ar_addr_d    = ar_addr_q;
    ar_size_d    = ar_size_q;
    signed_d     = signed_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          ar_addr_d   = bus.req_addr;
          ar_size_d   = bus.req_size;
          signed_d    = bus.req_signed;
          req_ready_d = 1'b0;
          if (req_illegal) begin
            state_d      = S_RSP;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = S_AR;
            ar_valid_d = 1'b1;
          end
        end
      end
      S_AR: begin
        if (bus.ar_ready) begin
          state_d    = S_R;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      S_R: begin
        // Beats for other IDs are drained with r_ready high and dropped.
        if (beat_ok) begin
          state_d      = S_RSP;
          r_ready_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = bus.r_resp[1];
          resp_data_d  = bus.r_resp[1] ? '0 :
                         extend_load(bus.r_data, ar_addr_q[LANE_W-1:0], ar_size_q, signed_q);
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      ar_addr_q    <= '0;
      ar_size_q    <= 3'd0;
      signed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      ar_addr_q    <= ar_addr_d;
      ar_size_q    <= ar_size_d;
      signed_q     <= signed_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.ar_valid   = ar_valid_q;
  assign bus.ar_addr    = ar_addr_q;
  assign bus.ar_size    = ar_size_q;
  assign bus.ar_id      = ARID_V;
  assign bus.ar_len     = 8'd0;
  assign bus.ar_burst   = 2'b01;
  assign bus.r_ready    = r_ready_q;
endmodule

// File: tb/tb_ysyx_22051013_axi_lsu_rd_master.sv
// Randomized self-checking bench for the LSU AXI read master against a byte-lane load model.
module tb_ysyx_22051013_axi_lsu_rd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22051013_axi_lsu_rd_master_if #(.ADDR_W(64), .DATA_W(64), .ID_W(4)) bus ();

  ysyx_22051013_axi_lsu_rd_master #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .ARID(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load result from first principles: pick bytes, mask, optionally sign-fill.
  function automatic void ref_model(input logic [63:0] addr, input logic [2:0] size, input logic sgn,
                                    input logic [63:0] rdata, input logic [1:0] rresp,
                                    output logic [63:0] d, output logic e);
    int unsigned nbytes;
    logic [63:0] v, mask;
    if (size > 3 || (addr % (64'd1 << size)) != 0 || rresp >= 2) begin
      d = 64'd0;
      e = 1'b1;
    end else begin
      nbytes = 1 << size;
      v = rdata >> ((addr % 8) * 8);
      if (nbytes < 8) begin
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        v = v & mask;
        if (sgn && v[8 * nbytes - 1]) v = v | ~mask;
      end
      d = v;
      e = 1'b0;
    end
  endfunction

  task automatic do_load(input logic [63:0] addr, input logic [2:0] size, input logic sgn,
                         input int ar_wait, input int r_wait, input int bad_beats,
                         input logic [63:0] rdata, input logic [1:0] rresp,
                         output logic [63:0] got);
    logic legal;
    logic [63:0] exp_data;
    logic exp_err;
    legal = (size <= 3) && ((addr % (64'd1 << size)) == 0);
    ref_model(addr, size, sgn, rdata, rresp, exp_data, exp_err);
    check_eq("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_size = size; bus.req_signed = sgn;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = {$urandom, $urandom};
    if (!legal) begin
      check_eq("ill_ar_valid", bus.ar_valid, 0);
      check_eq("ill_resp_valid", bus.resp_valid, 1);
      check_eq("ill_resp_err", bus.resp_err, 1);
      check_eq("ill_resp_data", bus.resp_data, 0);
      got = bus.resp_data;
      @(negedge clk);
      check_eq("ill_resp_pulse", bus.resp_valid, 0);
      check_eq("ill_ar_valid2", bus.ar_valid, 0);
      check_eq("ill_req_ready", bus.req_ready, 1);
      return;
    end
    for (int k = 0; k < ar_wait; k++) begin
      bus.r_valid = k[0]; bus.r_id = 4'd1; bus.r_data = ~rdata; bus.r_resp = 2'b00;
      check_eq("ar_valid_hold", bus.ar_valid, 1);
      check_eq("ar_addr_hold", bus.ar_addr, addr);
      check_eq("ar_size_hold", bus.ar_size, size);
      check_eq("r_ready_in_ar", bus.r_ready, 0);
      @(negedge clk);
    end
    bus.r_valid = 1'b0; bus.ar_ready = 1'b1;
    check_eq("ar_valid", bus.ar_valid, 1);
    check_eq("ar_addr", bus.ar_addr, addr);
    check_eq("ar_size", bus.ar_size, size);
    check_eq("ar_len", bus.ar_len, 0);
    check_eq("ar_burst", bus.ar_burst, 1);
    check_eq("ar_id", bus.ar_id, 1);
    @(negedge clk);
    bus.ar_ready = 1'b0;
    check_eq("ar_valid_drop", bus.ar_valid, 0);
    for (int k = 0; k < r_wait; k++) begin
      bus.r_valid = (k < bad_beats); bus.r_id = 4'd2; bus.r_data = {$urandom, $urandom}; bus.r_resp = 2'b00;
      check_eq("r_ready_wait", bus.r_ready, 1);
      check_eq("resp_valid_wait", bus.resp_valid, 0);
      @(negedge clk);
    end
    bus.r_valid = 1'b1; bus.r_id = 4'd1; bus.r_data = rdata; bus.r_resp = rresp;
    check_eq("r_ready", bus.r_ready, 1);
    @(negedge clk);
    bus.r_valid = 1'b0;
    check_eq("resp_valid", bus.resp_valid, 1);
    check_eq("resp_data", bus.resp_data, exp_data);
    check_eq("resp_err", bus.resp_err, exp_err);
    check_eq("r_ready_drop", bus.r_ready, 0);
    got = bus.resp_data;
    @(negedge clk);
    check_eq("resp_pulse", bus.resp_valid, 0);
    check_eq("req_ready_back", bus.req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] got;
    logic [63:0] pat;
    logic [63:0] addr;
    logic [2:0]  size;
    int          rw;
    pat = 64'h1122_3344_8566_7788;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_signed = 1'b0;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = '0;
    bus.r_id = '0; bus.r_last = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_ar_valid", bus.ar_valid, 0);
    check_eq("rst_r_ready", bus.r_ready, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_data", bus.resp_data, 0);
    check_eq("rst_resp_err", bus.resp_err, 0);
    check_eq("rst_ar_addr", bus.ar_addr, 0);
    check_eq("rst_ar_size", bus.ar_size, 0);
    check_eq("rst_ar_len", bus.ar_len, 0);
    check_eq("rst_ar_burst", bus.ar_burst, 1);
    check_eq("rst_ar_id", bus.ar_id, 1);

    do_load(64'h8000_0003, 3'd0, 1'b1, 0, 0, 0, pat, 2'b00, got);
    check_eq("plan_lb", got, 64'hFFFF_FFFF_FFFF_FF85);
    do_load(64'h8000_0003, 3'd0, 1'b0, 0, 0, 0, pat, 2'b00, got);
    check_eq("plan_lbu", got, 64'h85);
    do_load(64'h8000_0006, 3'd1, 1'b0, 0, 0, 0, pat, 2'b00, got);
    check_eq("plan_lhu", got, 64'h1122);
    do_load(64'h8000_0004, 3'd2, 1'b1, 0, 0, 0, pat, 2'b00, got);
    check_eq("plan_lw", got, 64'h1122_3344);
    do_load(64'h8000_0002, 3'd2, 1'b0, 0, 0, 0, pat, 2'b00, got);
    check_eq("plan_misalign", got, 64'h0);
    do_load(64'h8000_0000, 3'd3, 1'b0, 5, 7, 0, pat, 2'b00, got);
    check_eq("plan_ld_bp", got, pat);
    do_load(64'h8000_0000, 3'd3, 1'b0, 0, 1, 1, pat, 2'b10, got);
    check_eq("plan_slverr", got, 64'h0);
    do_load(64'h8000_0008, 3'd4, 1'b0, 0, 0, 0, pat, 2'b00, got);

    // Reset while the master is waiting in the R phase.
    bus.req_valid = 1'b1; bus.req_addr = 64'h8000_0000; bus.req_size = 3'd3; bus.req_signed = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0;
    check_eq("mid_r_ready", bus.r_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_req_ready", bus.req_ready, 1);
    check_eq("mid_r_ready_drop", bus.r_ready, 0);
    check_eq("mid_ar_valid", bus.ar_valid, 0);
    check_eq("mid_resp_valid", bus.resp_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("mid_no_resp", bus.resp_valid, 0);
    end
    do_load(64'h8000_0001, 3'd0, 1'b1, 0, 0, 0, pat, 2'b01, got);
    check_eq("post_rst_load", got, 64'h77);

    for (int n = 0; n < 60; n++) begin
      addr = 64'h8000_0000 + 64'($urandom_range(0, 15));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rw = $urandom_range(0, 4);
      do_load(addr, size, 1'($urandom), $urandom_range(0, 4), rw, $urandom_range(0, rw),
              {$urandom, $urandom}, 2'($urandom), got);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
